// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Opcodes, instruction field positions and flag indices shared
//               by the execute/decode slice.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORR = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_MVN = 4'h6;
  localparam logic [3:0] OP_LSL = 4'h7;
  localparam logic [3:0] OP_LSR = 4'h8;
  localparam logic [3:0] OP_ASR = 4'h9;
  localparam logic [3:0] OP_ROR = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_LDR = 4'hC;
  localparam logic [3:0] OP_STR = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;

  localparam int F_OP_HI = 27;
  localparam int F_OP_LO = 24;
  localparam int F_S     = 23;
  localparam int F_RD_HI = 22;
  localparam int F_RD_LO = 19;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  function automatic logic [15:0] rd_onehot(input logic [3:0] rd);
    return 16'(1) << rd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_decode_unit_if
// Description : Operand, instruction, address and result bundle of the slice.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_decode_unit_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      fetch;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic             seladdbusmux;
  logic [WIDTH-1:0] addbusaccess;
  logic [WIDTH-1:0] pcinstruct;
  logic [WIDTH-1:0] addressbus;
  logic [WIDTH-1:0] result;
  logic [15:0]      en;
  logic             n;
  logic             z;
  logic             c;
  logic             v;

  modport master (
    output fetch, s1, s2, seladdbusmux, addbusaccess, pcinstruct,
    input  addressbus, result, en, n, z, c, v
  );

  modport slave (
    input  fetch, s1, s2, seladdbusmux, addbusaccess, pcinstruct,
    output addressbus, result, en, n, z, c, v
  );
endinterface
`default_nettype wire

// File: rtl/exec_shifter.sv
`default_nettype none
// ============================================================================
// Module      : exec_shifter
// Description : 32-bit barrel shifter (LSL/LSR/ASR/ROR) with carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_shifter
  import exec_pkg::*;
(
  input  wire logic [31:0] i_a,
  input  wire logic [4:0]  i_amt,
  input  wire logic [1:0]  i_type,
  output logic      [31:0] o_res,
  output logic             o_co
);

  // Extra bit beside the operand catches the last bit shifted out.
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [32:0] w_asr;
  logic [31:0] w_ror;

  assign w_lsl = {1'b0, i_a} << i_amt;
  assign w_lsr = {i_a, 1'b0} >> i_amt;
  assign w_asr = $signed({i_a, 1'b0}) >>> i_amt;
  assign w_ror = 32'({i_a, i_a} >> i_amt);

  always_comb begin
    o_res = w_lsl[31:0];
    o_co  = w_lsl[32];
    case (i_type)
      SH_LSR: begin
        o_res = w_lsr[32:1];
        o_co  = w_lsr[0];
      end
      SH_ASR: begin
        o_res = w_asr[32:1];
        o_co  = w_asr[0];
      end
      SH_ROR: begin
        o_res = w_ror;
        o_co  = w_ror[31];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exec_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_decode_unit
// Description : Write-enable decode, ALU, address mux and NZCV register.
//               Shift ops (7-A) exist only when ALU_SHIFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_decode_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic          clk,
  input wire logic          reset,
  exec_decode_unit_if.slave bus
);

  logic [3:0]       w_op;
  logic             w_s;
  logic [3:0]       w_rd;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_sh_res;
  logic             w_sh_co;
  logic             w_writes;
  logic             w_flag_op;
  logic             w_we;
  logic             w_c_upd;
  logic             w_c_val;
  logic             w_v_upd;
  logic             w_v_val;
  logic             w_unused_bits;
  logic [3:0]       r_flags;

  assign w_op  = bus.fetch[F_OP_HI:F_OP_LO];
  assign w_s   = bus.fetch[F_S];
  assign w_rd  = bus.fetch[F_RD_HI:F_RD_LO];
  assign w_a   = bus.s2;
  assign w_b   = bus.s1;
  assign w_unused_bits = &{1'b0, bus.fetch[31:28], bus.fetch[18:0]};

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

`ifdef ALU_SHIFT_EN
  localparam logic c_shift_en = 1'b1;
  exec_shifter u_shifter (
    .i_a    (w_a),
    .i_amt  (w_b[4:0]),
    .i_type (2'(w_op - OP_LSL)),
    .o_res  (w_sh_res),
    .o_co   (w_sh_co)
  );
`else
  localparam logic c_shift_en = 1'b0;
  assign w_sh_res = '0;
  assign w_sh_co  = 1'b0;
`endif

  always_comb begin
    w_res     = '0;
    w_writes  = 1'b0;
    w_flag_op = 1'b0;
    w_c_upd   = 1'b0;
    w_c_val   = 1'b0;
    w_v_upd   = 1'b0;
    w_v_val   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res     = w_sum[WIDTH-1:0];
        w_writes  = 1'b1;
        w_flag_op = 1'b1;
        w_c_upd   = 1'b1;
        w_c_val   = w_sum[WIDTH];
        w_v_upd   = 1'b1;
        w_v_val   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // Carry is the inverse of the borrow out of the widened subtract.
        w_res     = w_diff[WIDTH-1:0];
        w_writes  = (w_op == OP_SUB);
        w_flag_op = 1'b1;
        w_c_upd   = 1'b1;
        w_c_val   = ~w_diff[WIDTH];
        w_v_upd   = 1'b1;
        w_v_val   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_MVN: begin
        w_writes  = 1'b1;
        w_flag_op = 1'b1;
        case (w_op)
          OP_AND:  w_res = w_a & w_b;
          OP_ORR:  w_res = w_a | w_b;
          OP_EOR:  w_res = w_a ^ w_b;
          OP_MOV:  w_res = w_b;
          default: w_res = ~w_b;
        endcase
      end
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        if (c_shift_en) begin
          w_res     = w_sh_res;
          w_writes  = 1'b1;
          w_flag_op = 1'b1;
          w_c_upd   = |w_b[4:0];
          w_c_val   = w_sh_co;
        end
      end
      OP_LDR: begin
        w_res    = w_a;
        w_writes = 1'b1;
      end
      OP_STR: w_res = w_a;
      default: ;
    endcase
  end

  assign w_we = (w_op == OP_CMP) || (w_s && w_flag_op);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_we) begin
      r_flags[FLAG_N] <= w_res[WIDTH-1];
      r_flags[FLAG_Z] <= (w_res == '0);
      if (w_c_upd) r_flags[FLAG_C] <= w_c_val;
      if (w_v_upd) r_flags[FLAG_V] <= w_v_val;
    end
  end

  assign bus.result     = w_res;
  assign bus.en         = w_writes ? rd_onehot(w_rd) : 16'h0000;
  assign bus.addressbus = bus.seladdbusmux ? bus.addbusaccess : bus.pcinstruct;
  assign bus.n          = r_flags[FLAG_N];
  assign bus.z          = r_flags[FLAG_Z];
  assign bus.c          = r_flags[FLAG_C];
  assign bus.v          = r_flags[FLAG_V];

endmodule
`default_nettype wire

// File: tb/tb_exec_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_decode_unit
// Description : Directed and random checks of exec_decode_unit against a
//               behavioural model of the instruction set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_decode_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   mn, mz, mc, mv;

  exec_decode_unit_if #(.WIDTH(32)) bus ();

  exec_decode_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input bit s, input int rd);
    logic [31:0] f;
    f = 32'h0;
    f[27:24] = 4'(op);
    f[23]    = s;
    f[22:19] = 4'(rd);
    return f;
  endfunction

  // Instruction-level model: result, write enable and flag effects.
  task automatic model(input logic [31:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [15:0] en,
                       output bit we, output bit cu, output bit cval,
                       output bit vu, output bit vval);
    int          op, rd, k;
    bit          s, shift_ok, writes, is_shift;
    logic [63:0] w64;
    logic [31:0] t;
    longint      ss;
`ifdef ALU_SHIFT_EN
    shift_ok = 1'b1;
`else
    shift_ok = 1'b0;
`endif
    op = int'(f[27:24]);
    s  = f[23];
    rd = int'(f[22:19]);
    k  = int'(b[4:0]);
    res = 32'h0; cu = 0; cval = 0; vu = 0; vval = 0;
    is_shift = (op >= 7 && op <= 10);
    case (op)
      0: begin
        w64 = {32'h0, a} + {32'h0, b};
        res = w64[31:0]; cu = 1; cval = w64[32];
        ss = longint'($signed(a)) + longint'($signed(b));
        vu = 1; vval = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      1, 11: begin
        res = a - b; cu = 1; cval = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        vu = 1; vval = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = b;
      6: res = ~b;
      7: if (shift_ok) begin
        w64 = {32'h0, a} << k; res = w64[31:0];
        cu = (k != 0); cval = w64[32];
      end
      8: if (shift_ok) begin
        res = a >> k;
        if (k != 0) begin t = a >> (k - 1); cu = 1; cval = t[0]; end
      end
      9: if (shift_ok) begin
        res = $signed(a) >>> k;
        if (k != 0) begin t = $signed(a) >>> (k - 1); cu = 1; cval = t[0]; end
      end
      10: if (shift_ok) begin
        res = (k == 0) ? a : ((a >> k) | (a << (32 - k)));
        if (k != 0) begin cu = 1; cval = res[31]; end
      end
      12, 13: res = a;
      default: res = 32'h0;
    endcase
    writes = (op <= 12) && (op != 11) && (!is_shift || shift_ok);
    en = writes ? 16'(1 << rd) : 16'h0;
    we = (op == 11) || (s && op <= 10 && (!is_shift || shift_ok));
  endtask

  task automatic run_instr(input logic [31:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic rst_n);
    logic [31:0] res;
    logic [15:0] en;
    bit          we, cu, cval, vu, vval;
    bus.fetch        = f;
    bus.s2           = a;
    bus.s1           = b;
    bus.seladdbusmux = 1'($urandom_range(0, 1));
    bus.addbusaccess = $urandom;
    bus.pcinstruct   = $urandom;
    reset            = rst_n;
    #1;
    model(f, a, b, res, en, we, cu, cval, vu, vval);
    check_val("result", bus.result, res);
    check_val("en", {16'h0, bus.en}, {16'h0, en});
    check_val("addressbus", bus.addressbus,
              bus.seladdbusmux ? bus.addbusaccess : bus.pcinstruct);
    @(posedge clk);
    if (!rst_n) begin
      mn = 0; mz = 0; mc = 0; mv = 0;
    end else if (we) begin
      mn = res[31];
      mz = (res == 32'h0);
      if (cu) mc = cval;
      if (vu) mv = vval;
    end
    #1;
    check_val("nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, {28'h0, mn, mz, mc, mv});
  endtask

  initial begin
    logic [31:0] a, b, f;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.fetch = 32'h0; bus.s1 = 32'h0; bus.s2 = 32'h0;
    bus.seladdbusmux = 1'b0; bus.addbusaccess = 32'h0; bus.pcinstruct = 32'h0;
    mn = 0; mz = 0; mc = 0; mv = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, 32'h0);

    // Reset beats a flag-setting ADD, then the same ADD updates normally.
    run_instr(mk(0, 1, 3), 32'h7FFF_FFFF, 32'h1, 1'b0);
    check_val("rst_hold_nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, 32'h0);
    run_instr(mk(0, 1, 3), 32'h7FFF_FFFF, 32'h1, 1'b1);
    check_val("add_ovf_res", bus.result, 32'h8000_0000);
    check_val("add_ovf_nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, 32'h9);

    run_instr(mk(11, 0, 7), 32'h5, 32'h5, 1'b1);
    check_val("cmp_nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, 32'h6);

    bus.fetch = mk(12, 1, 15);
    #1;
    check_val("ldr_en", {16'h0, bus.en}, 32'h8000);
    run_instr(mk(12, 1, 15), 32'h1234, 32'h0, 1'b1);
    check_val("ldr_nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, 32'h6);
    run_instr(mk(13, 1, 4), 32'h0, 32'h0, 1'b1);

    bus.pcinstruct = 32'h10; bus.addbusaccess = 32'hABCD; bus.seladdbusmux = 1'b0;
    #1;
    check_val("addr_pc", bus.addressbus, 32'h10);
    bus.seladdbusmux = 1'b1;
    #1;
    check_val("addr_acc", bus.addressbus, 32'hABCD);

    run_instr(mk(8, 1, 2), 32'h3, 32'h1, 1'b1);
`ifdef ALU_SHIFT_EN
    check_val("lsr_res", bus.result, 32'h1);
    check_val("lsr_c", {31'h0, bus.c}, 32'h1);
`else
    check_val("lsr_res", bus.result, 32'h0);
    check_val("lsr_en", {16'h0, bus.en}, 32'h0);
    check_val("lsr_nzcv", {28'h0, bus.n, bus.z, bus.c, bus.v}, 32'h6);
`endif

    for (int i = 0; i < 600; i++) begin
      f = $urandom;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(0, 40);
        1: b = a;
        2: begin a = 32'h7FFF_FFFF ^ 32'($urandom_range(0, 1)); b = 32'($urandom_range(0, 2)); end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF ^ 32'($urandom_range(0, 3)); end
        default: b = $urandom;
      endcase
      run_instr(f, a, b, ($urandom_range(0, 15) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_decode_unit.md
# exec_decode_unit

Combinational execute/decode slice of the 32-bit processor datapath, plus a registered NZCV status register. It contains three functions:
- Destination-register write-enable decode (the `decoder` function).
- A 32-bit ALU with shifter (the `alu` function).
- A memory address-bus source multiplexer (the `addbus_mux` function).

It sits between the register-bank read muxes (s1/s2), the register bank write enables, and the RAM address port.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: system clock; rising edge.
- `reset` in 1: reset is synchronous and active-low (already decided).
- `fetch` in 32: current instruction word.
- `s1` in 32: operand B, register selected by fetch[14:11].
- `s2` in 32: operand A, register selected by fetch[18:15].
- `seladdbusmux` in 1: address source select; 1 = `addbusaccess`, 0 = `pcinstruct`.
- `addbusaccess` in 32: data-access address from memory control.
- `pcinstruct` in 32: instruction fetch address from the PC counter.
- `addressbus` out 32: RAM address.
- `result` out 32: ALU result.
- `en` out 16: one-hot register write enable.
- `n`, `z`, `c`, `v` out 1 each: registered status flags.

## Operation
Instruction fields:
- [27:24] op
- [23] S (set flags)
- [22:19] Rd
- [18:15] Rn
- [14:11] Rm
- Other bits are ignored.

Opcodes (A = s2, B = s1, shift amount = B[4:0]):

| op | Mnemonic | result |
|---|---|---|
| 0 | ADD | A+B |
| 1 | SUB | A−B |
| 2 | AND | A&B |
| 3 | ORR | A\|B |
| 4 | EOR | A^B |
| 5 | MOV | B |
| 6 | MVN | ~B |
| 7 | LSL | A shifted left |
| 8 | LSR | A shifted right, logical |
| 9 | ASR | A shifted right, arithmetic |
| A | ROR | A rotated right |
| B | CMP | A−B; no register write; always sets flags |
| C | LDR | result = A (pass-through); Rd is written |
| D | STR | result = A; no write |
| E, F | NOP | result = 0; no write |

- `en`:
  - For op 0–C except B: `en` = 1 << Rd.
  - Otherwise `en` = 0.
  - Combinational.
- Flag candidates:
  - n = result[31].
  - z = (result == 0).
  - ADD: c = carry out of bit 31; v = signed overflow.
  - SUB/CMP: c = NOT borrow (A ≥ B unsigned); v = signed overflow of A−B.
  - Shifts: c = last bit shifted out; with amount 0, c and v are unchanged.
  - Logic/MOV/MVN: c and v are unchanged.
- Flag register update:
  - Updated when (S = 1 and op ≤ A) or op = B.
  - Not updated for ops C–F, regardless of S.
- `addressbus` = `seladdbusmux` ? `addbusaccess` : `pcinstruct`. Purely combinational; an X on `seladdbusmux` yields X.

## Timing
- `result`, `en` and `addressbus` are combinational from the inputs, with zero cycle latency.
- n/z/c/v are registered: they reflect the instruction present at the preceding rising edge of `clk`.
- Reset:
  - `reset` = 0 at a rising edge clears n, z, c and v to 0.
  - Reset takes priority over a simultaneous flag update.
  - Combinational outputs are not affected by reset.
- Reset asserted mid-program clears the flags only. The next qualifying instruction after `reset` returns to 1 updates them normally.
- Shift amounts of 0–31 use only B[4:0]; upper bits of B are ignored. ROR by 0 returns A.

## Configuration
- `ALU_SHIFT_EN` defined:
  - Ops 7–A implemented as above.
- Not defined:
  - Ops 7–A behave as NOP: result 0, `en` 0, no flag update.
  - The shifter is not synthesised.

## Structure
- Shared package `exec_pkg`:
  - Opcode enum/localparams (OP_ADD … OP_NOP).
  - Instruction field bit positions.
  - Flag-vector index constants.
- One natural sub-module, `exec_shifter`: 32-bit barrel shifter taking A, amount[4:0] and type[1:0], producing result and carry-out. It is instantiated only under `ALU_SHIFT_EN`.
- Decode, address mux and flag register are inline in the top module.

## Test plan
- Reset: hold `reset` = 0 for one edge with an ADD S=1 in flight → n z c v = 0000; release → next ADD S=1 updates the flags.
- ADD with S=1, A = 0x7FFFFFFF, B = 1, Rd = 3 → result 0x80000000, `en` = 0x0008; after the edge n=1, z=0, c=0, v=1.
- CMP, A = B = 0x00000005, S=0 → `en` = 0; after the edge z=1, c=1, n=0, v=0.
- LDR, Rd = 15 → `en` = 0x8000, flags unchanged. STR → `en` = 0.
- `addressbus` with `seladdbusmux` 0 then 1, `pcinstruct` = 0x10, `addbusaccess` = 0xABCD → 0x10 then 0xABCD, same delta.
- LSR with S=1, A = 0x00000003, B = 1 (`ALU_SHIFT_EN` defined) → result 1, c=1. Without the macro → result 0, `en` 0, flags unchanged.
